// File: rtl/line_buffer_dbl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_buffer_dbl : double-buffered scanline buffer, renderer -> composer    |
// |                   with handshaked swap, hardware clear and overrun flag.   |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module line_buffer_dbl #(
    parameter int unsigned            DATA_WIDTH  = 8,
    parameter int unsigned            LINE_LEN    = 640,
    parameter int unsigned            IDX_WIDTH   = 10,
    parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  swap_req,
    input  logic                  clear_en,
    output logic                  render_ready,
    output logic                  active_render_buffer,
    input  logic [IDX_WIDTH-1:0]  renderer_wr_idx,
    input  logic [DATA_WIDTH-1:0] renderer_wr_data,
    input  logic                  renderer_wr_en,
    input  logic [IDX_WIDTH-1:0]  composer_rd_idx,
    output logic [DATA_WIDTH-1:0] composer_rd_data,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    // One extra bit so LINE_LEN == 2**IDX_WIDTH still compares correctly.
    localparam logic [IDX_WIDTH:0]   c_LEN  = (IDX_WIDTH+1)'(LINE_LEN);
    localparam logic [IDX_WIDTH-1:0] c_LAST = IDX_WIDTH'(LINE_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_render_ready;
    logic                  r_active;
    logic                  r_overrun;
    logic [IDX_WIDTH-1:0]  r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_clearing;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_accept;
    logic                  w_mem_we;
    logic                  w_overrun_set;
    logic [IDX_WIDTH-1:0]  w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic [DATA_WIDTH-1:0] w_bank_rd [2];

    assign w_clearing    = (r_state == S_CLEAR);
    assign w_wr_in_range = ({1'b0, renderer_wr_idx} < c_LEN);
    assign w_rd_in_range = ({1'b0, composer_rd_idx} < c_LEN);
    assign w_wr_accept   = renderer_wr_en && r_render_ready && w_wr_in_range;
    assign w_overrun_set = (swap_req && w_clearing) || (renderer_wr_en && !r_render_ready);

    // The clear sequencer and the renderer never write in the same cycle,
    // so both share the single write port of the current render bank.
    assign w_mem_we   = w_wr_accept || w_clearing;
    assign w_mem_addr = w_clearing ? r_clr_cnt   : renderer_wr_idx;
    assign w_mem_data = w_clearing ? CLEAR_VALUE : renderer_wr_data;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            logic [DATA_WIDTH-1:0] r_mem [LINE_LEN];

            always_ff @(posedge clk) begin
                if (w_mem_we && (r_active == 1'(b))) begin
                    r_mem[w_mem_addr] <= w_mem_data;
                end
            end

            assign w_bank_rd[b] = r_mem[composer_rd_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_render_ready <= 1'b1;
            r_active       <= 1'b0;
            r_clr_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (swap_req) begin
                        r_active <= ~r_active;
                        if (clear_en) begin
                            r_state        <= S_CLEAR;
                            r_render_ready <= 1'b0;
                            r_clr_cnt      <= '0;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == c_LAST) begin
                        r_state        <= S_IDLE;
                        r_render_ready <= 1'b1;
                        r_clr_cnt      <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_render_ready <= 1'b1;
                    r_clr_cnt      <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // Bank select uses the pre-edge render index, so a swap-cycle read
    // still sees the old composer bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= CLEAR_VALUE;
        end else if (w_rd_in_range) begin
            r_rd_data <= w_bank_rd[~r_active];
        end else begin
            r_rd_data <= CLEAR_VALUE;
        end
    end

    assign render_ready         = r_render_ready;
    assign active_render_buffer = r_active;
    assign overrun              = r_overrun;
    assign composer_rd_data     = r_rd_data;

endmodule
`default_nettype wire

// File: doc/line_buffer_dbl.md
Name: line_buffer_dbl

Overview:
- Parametrised double-buffered scanline buffer between one layer renderer (write side) and the composer (read side); successor to the fixed 8-bit, 640-entry layer line buffer.
- Generalised in data width and line length.
- Adds a handshaked buffer swap, an optional hardware clear of the freshly released render buffer, and sticky overrun reporting.
- One instance per layer or sprite plane.

Parameters:
- DATA_WIDTH, 8, bits per pixel entry.
- LINE_LEN, 640, valid entries per line; must be ≤ 2**IDX_WIDTH.
- IDX_WIDTH, 10, width of the read and write index ports.
- CLEAR_VALUE, 0, entry value written by the clear sequencer and returned for out-of-range reads.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- swap_req  in  1  one-cycle pulse at end of line requesting a buffer swap.
- clear_en  in  1  when 1, an accepted swap starts a clear of the new render buffer.
- render_ready  out  1  1 = renderer writes are accepted.
- active_render_buffer  out  1  index (0/1) of the buffer currently written by the renderer.
- renderer_wr_idx  in  IDX_WIDTH  write index.
- renderer_wr_data  in  DATA_WIDTH  write data.
- renderer_wr_en  in  1  write strobe.
- composer_rd_idx  in  IDX_WIDTH  read index.
- composer_rd_data  out  DATA_WIDTH  read data, 1-cycle latency.
- overrun  out  1  sticky error flag.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Storage: two banks (buffer 0 and buffer 1), each LINE_LEN x DATA_WIDTH, inferred dual-port RAM.
  - Composer always reads bank !active_render_buffer.
- Reset (rst_n=0 at a clk edge), including during an active clear:
  - state=IDLE, active_render_buffer=0, render_ready=1, overrun=0, clear counter=0, composer_rd_data=CLEAR_VALUE.
  - RAM contents are not reset and are undefined.
- FSM states: IDLE and CLEAR.
  - IDLE: render_ready=1.
    - swap_req=1 → active_render_buffer toggles at the same edge.
    - If clear_en=1, next state is CLEAR with counter=0; otherwise stay IDLE.
  - CLEAR: render_ready=0.
    - Each cycle writes CLEAR_VALUE to new render bank [counter], then counter increments.
    - At counter==LINE_LEN-1 the last write occurs and the next state is IDLE; the clear takes exactly LINE_LEN cycles.
    - swap_req in CLEAR is ignored (no toggle) and sets overrun.
- Renderer writes:
  - Accepted when renderer_wr_en=1, render_ready=1 and renderer_wr_idx<LINE_LEN; written to the current render bank.
  - Write and swap_req in the same cycle: the write lands in the pre-swap render bank.
  - renderer_wr_en=1 while render_ready=0: write dropped, overrun set.
  - Index ≥ LINE_LEN: write silently dropped, no flag.
- Composer reads:
  - composer_rd_data is registered: data for the index presented at cycle N appears at cycle N+1.
  - The bank is selected by active_render_buffer as sampled at cycle N, so a read issued in the swap cycle returns the pre-swap composer bank.
  - Index ≥ LINE_LEN returns CLEAR_VALUE at N+1.
  - Reads are unaffected by render_ready or the clear sequencer.
- overrun:
  - Set-dominant: set and overrun_clr in the same cycle leaves overrun=1.
  - Otherwise overrun_clr=1 clears it at the next edge.
- Width rules: the clear counter is IDX_WIDTH bits and never exceeds LINE_LEN-1.

Test Plan:
- Reset then basic read:
  - Stimulus: rst_n low 2 cycles, release; write idx 5=0xA5 into bank 0; swap_req with clear_en=0; read idx 5.
  - Required: composer_rd_data=0xA5 exactly 1 cycle after the index is presented.
  - Required: active_render_buffer=1 immediately after the swap edge.
- Clear sequence:
  - Stimulus: fill bank 1 with 0xFF; swap with clear_en=1 (render becomes 0); swap again after idle.
  - Required: render_ready low for exactly 640 cycles after the first swap.
  - Required: after the second swap, reads of bank 0 at idx 0, 319 and 639 return 0x00.
- Overrun paths:
  - Stimulus: during CLEAR, pulse swap_req and also assert renderer_wr_en.
  - Required: active_render_buffer unchanged and overrun=1.
  - Stimulus: overrun_clr together with a new violation.
  - Required: overrun stays 1; a lone overrun_clr then clears it.
- Boundaries:
  - Stimulus: write idx 639=0x11 and idx 700=0x22; swap; read 639 and 700.
  - Required: reads return 0x11 and CLEAR_VALUE respectively.
  - Required: write and swap_req in the same cycle lands in the old bank.
- Reset mid-clear:
  - Stimulus: assert rst_n=0 at clear cycle 100.
  - Required: next cycle shows render_ready=1, active_render_buffer=0, overrun=0, and the FSM is IDLE.
- Parametrisation:
  - Stimulus: rerun scenarios 1–4 with DATA_WIDTH=4, LINE_LEN=320, IDX_WIDTH=9, CLEAR_VALUE=4'hF.
  - Required: the clear takes 320 cycles and out-of-range reads return 0xF.
